// File: rtl/cordic_vec_pkg.sv
// Shared constants for the vectoring CORDIC: Q4.30 angle constants, gain
// inverse, atan(2^-i) table and the controller state encoding.
package cordic_vec_pkg;
  localparam int FRAC = 30;
  localparam int IW   = 4 + FRAC;

  localparam logic signed [IW-1:0] HALF_PI = 34'sh6487_ED51;
  localparam logic signed [IW-1:0] PI      = 34'shC90F_DAA2;
  localparam logic signed [IW-1:0] K_INV   = 34'sh26DD_3B6A;

  typedef enum logic [2:0] {IDLE, PRE, ITER, COMP, PACK, DONE} state_t;

  function automatic logic signed [IW-1:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  atan_lut = 34'sh3243_F6A9;
      5'd1:  atan_lut = 34'sh1DAC_6705;
      5'd2:  atan_lut = 34'sh0FAD_BAFC;
      5'd3:  atan_lut = 34'sh07F5_6EA6;
      5'd4:  atan_lut = 34'sh03FE_AB76;
      5'd5:  atan_lut = 34'sh01FF_D55B;
      5'd6:  atan_lut = 34'sh00FF_FAAA;
      5'd7:  atan_lut = 34'sh007F_FF55;
      5'd8:  atan_lut = 34'sh003F_FFEA;
      5'd9:  atan_lut = 34'sh001F_FFFD;
      5'd10: atan_lut = 34'sh000F_FFFF;
      5'd11: atan_lut = 34'sh0007_FFFF;
      5'd12: atan_lut = 34'sh0003_FFFF;
      5'd13: atan_lut = 34'sh0001_FFFF;
      5'd14: atan_lut = 34'sh0000_FFFF;
      5'd15: atan_lut = 34'sh0000_7FFF;
      5'd16: atan_lut = 34'sh0000_3FFF;
      5'd17: atan_lut = 34'sh0000_1FFF;
      5'd18: atan_lut = 34'sh0000_0FFF;
      5'd19: atan_lut = 34'sh0000_07FF;
      5'd20: atan_lut = 34'sh0000_03FF;
      5'd21: atan_lut = 34'sh0000_01FF;
      5'd22: atan_lut = 34'sh0000_00FF;
      5'd23: atan_lut = 34'sh0000_007F;
      5'd24: atan_lut = 34'sh0000_003F;
      5'd25: atan_lut = 34'sh0000_001F;
      5'd26: atan_lut = 34'sh0000_000F;
      5'd27: atan_lut = 34'sh0000_0008;
      5'd28: atan_lut = 34'sh0000_0004;
      5'd29: atan_lut = 34'sh0000_0002;
      default: atan_lut = '0;
    endcase
  endfunction
endpackage

// File: rtl/fix_to_fp32.sv
// Combinational signed fixed-point to fp32 normaliser (mantissa truncated,
// zero maps to +0).
module fix_to_fp32 #(
  parameter int IW   = 34,
  parameter int FRAC = 30
) (
  input  logic signed [IW-1:0] v_i,
  output logic [31:0]          f_o
);
  logic [IW-1:0] mag, norm;
  int            pos;

  always_comb begin
    mag = v_i[IW-1] ? -v_i : v_i;
    pos = 0;
    for (int b = 0; b < IW; b++)
      if (mag[b]) pos = b;
    // Left-justify so the hidden one lands on the MSB.
    norm = mag << (IW - 1 - pos);
    f_o  = '0;
    if (mag != '0)
      f_o = {v_i[IW-1], 8'(127 + pos - FRAC), norm[IW-2 -: 23]};
  end
endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: fp32 (x, y) -> fp32 atan2 angle and magnitude.
// Define CORDIC_VECTOR_GAIN_COMP_EN to add a K_INV gain-compensation step.
import cordic_vec_pkg::*;

module cordic_vector #(
  parameter int M             = 20,
  parameter int W             = 32,
  parameter int FRACTION_BITS = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] angle,
  output logic [W-1:0] magnitude,
  output logic         err
);
  localparam int IWL = 4 + FRACTION_BITS;
  localparam int PW  = 2 * IWL;

  state_t                state_q, state_d;
  logic signed [IWL-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [IWL-1:0] xs, ys, x_fix, y_fix;
  logic [4:0]            i_q, i_d;
  logic [W-1:0]          angle_q, angle_d, mag_q, mag_d, angle_f, mag_f;
  logic                  err_q, err_d, x_err, y_err;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  logic signed [PW-1:0]  prod;
`endif

  // Returns {err, Q4.30 value}; underflowing magnitudes flush to zero.
  function automatic logic [IWL:0] to_fix(input logic [31:0] f);
    logic [IWL-1:0] v;
    logic           e;
    int             sh;
    v  = '0;
    e  = 1'b0;
    sh = 127 - int'(f[30:23]);
    if (f[30:23] == 8'hFF || sh < 0)
      e = 1'b1;
    else if (f[30:23] != 8'd0 && sh <= FRACTION_BITS) begin
      v = IWL'({1'b1, f[22:0]}) << (FRACTION_BITS - 23);
      v = v >> sh;
      if (f[31]) v = -v;
    end
    return {e, v};
  endfunction

  assign {x_err, x_fix} = to_fix(x_in);
  assign {y_err, y_fix} = to_fix(y_in);

  fix_to_fp32 #(.IW(IWL), .FRAC(FRACTION_BITS)) u_ang (.v_i(z_q), .f_o(angle_f));
  fix_to_fp32 #(.IW(IWL), .FRAC(FRACTION_BITS)) u_mag (.v_i(x_q), .f_o(mag_f));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    err_d   = err_q;
    xs      = x_q >>> i_q;
    ys      = y_q >>> i_q;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
    prod    = PW'(x_q) * PW'(K_INV);
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        x_d = x_fix;
        y_d = y_fix;
        if (x_err || y_err) begin
          angle_d = '0; mag_d = '0; err_d = 1'b1;
          state_d = DONE;
        end else if (x_fix == '0 && y_fix == '0) begin
          angle_d = '0; mag_d = '0; err_d = 1'b0;
          state_d = DONE;
        end else
          state_d = PRE;
      end
      PRE: begin
        // Fold left half-plane into the CORDIC convergence range.
        z_d = '0;
        if (x_q < 0) begin
          if (y_q >= 0) begin
            x_d = y_q;  y_d = -x_q; z_d = HALF_PI;
          end else begin
            x_d = -y_q; y_d = x_q;  z_d = -HALF_PI;
          end
        end
        i_d     = '0;
        state_d = ITER;
      end
      ITER: begin
        if (!y_q[IWL-1]) begin
          x_d = x_q + ys; y_d = y_q - xs; z_d = z_q + atan_lut(i_q);
        end else begin
          x_d = x_q - ys; y_d = y_q + xs; z_d = z_q - atan_lut(i_q);
        end
        i_d = i_q + 5'd1;
        if (i_q == 5'(M - 1)) begin
          i_d = '0;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
          state_d = COMP;
`else
          state_d = PACK;
`endif
        end
      end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
      COMP: begin
        x_d     = prod[FRACTION_BITS +: IWL];
        state_d = PACK;
      end
`endif
      PACK: begin
        angle_d = angle_f;
        mag_d   = mag_f;
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      angle_q <= '0;
      mag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign angle     = angle_q;
  assign magnitude = mag_q;
  assign err       = err_q;
endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: latency, accuracy, error paths,
// backpressure and mid-operation reset.
module tb_cordic_vector;
  localparam int M = 20;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  localparam int  LAT  = M + 4;
  localparam real GAIN = 1.0;
`else
  localparam int  LAT  = M + 3;
  localparam real GAIN = 1.6467602581;
`endif

  logic        clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] x_in, y_in, angle, magnitude;

  typedef struct {
    real ang;
    real mag;
    bit  err;
    bit  exact;
    int  lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cordic_vector #(.M(M), .W(32), .FRACTION_BITS(30)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .angle(angle), .magnitude(magnitude), .err(err)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    real r;
    int  ex;
    if (f[30:23] == 8'd0) return 0.0;
    r  = 1.0 + real'(f[22:0]) / 8388608.0;
    ex = int'(f[30:23]) - 127;
    while (ex > 0) begin r = r * 2.0; ex--; end
    while (ex < 0) begin r = r / 2.0; ex++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    b = $realtobits(r);
    return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
  endfunction

  function automatic bit is_err(input logic [31:0] f);
    return (f[30:23] == 8'hFF) || (f[30:23] > 8'd127);
  endfunction

  function automatic bit is_zero(input logic [31:0] f);
    return (127 - int'(f[30:23])) > 30;
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    real  xr, yr;
    e.err   = is_err(x) || is_err(y);
    e.exact = e.err || (is_zero(x) && is_zero(y));
    e.lat   = e.exact ? 1 : LAT;
    e.ang   = 0.0;
    e.mag   = 0.0;
    if (!e.exact) begin
      xr    = is_zero(x) ? 0.0 : f2r(x);
      yr    = is_zero(y) ? 0.0 : f2r(y);
      e.ang = $atan2(yr, xr);
      e.mag = $sqrt(xr * xr + yr * yr) * GAIN;
    end
    return e;
  endfunction

  function automatic bit close(input real a, input real e);
    real d, t;
    d = (a > e) ? a - e : e - a;
    t = ((e < 0.0) ? -e : e) * 1.52587890625e-5 + 9.5367431640625e-7;
    return d <= t;
  endfunction

  function automatic real rnd();
    real v;
    v = real'($urandom_range(250, 1400)) / 1000.0;
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int hold,
                        input string name);
    exp_t        e;
    int          k;
    bit          got;
    logic [31:0] a0, m0;
    logic        e0;
    @(negedge clk);
    in_valid = 1'b1; x_in = x; y_in = y;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_idle: got %b want 1", name, in_ready);
    end
    sb.push_back(model(x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL %s in_ready_busy: got %b want 0", name, in_ready);
    end
    k = 1; got = 1'b0;
    while (k < 200) begin
      if (out_valid === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1; k++;
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s timeout: no out_valid within %0d cycles", name, k);
      return;
    end
    if (k != e.lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, k, e.lat);
    end
    checks++;
    if (err !== e.err) begin
      errors++; $display("FAIL %s err: got %b want %b", name, err, e.err);
    end
    checks++;
    if (e.exact) begin
      if (angle !== 32'h0 || magnitude !== 32'h0) begin
        errors++;
        $display("FAIL %s zero_outputs: got angle %h mag %h want 0 0", name, angle, magnitude);
      end
    end else begin
      if (!close(f2r(angle), e.ang)) begin
        errors++; $display("FAIL %s angle: got %h (%f) want %f", name, angle, f2r(angle), e.ang);
      end
      checks++;
      if (!close(f2r(magnitude), e.mag)) begin
        errors++;
        $display("FAIL %s magnitude: got %h (%f) want %f", name, magnitude, f2r(magnitude), e.mag);
      end
    end
    a0 = angle; m0 = magnitude; e0 = err;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      in_valid = 1'b1; x_in = 32'h3F000000; y_in = 32'h3E800000;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || angle !== a0 || magnitude !== m0 || err !== e0) begin
        errors++;
        $display("FAIL %s hold[%0d]: got v=%b rdy=%b a=%h m=%h e=%b want v=1 rdy=0 a=%h m=%h e=%b",
                 name, c, out_valid, in_ready, angle, magnitude, err, a0, m0, e0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: got v=%b rdy=%b want v=0 rdy=1", name, out_valid, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (angle !== 32'h0 || magnitude !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_out: got a=%h m=%h e=%b want 0 0 0", angle, magnitude, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_quadrants();
    run_op(32'h3F800000, 32'h3F800000, 0, "diag_1_1");
    run_op(32'hBF800000, 32'h00000000, 0, "neg_x_axis");
    run_op(32'h00000000, 32'hBF000000, 0, "neg_y_axis");
    run_op(32'hBF400000, 32'hBF200000, 0, "third_quad");
    run_op(32'h3FF00000, 32'hBFF00000, 0, "near_limit");
  endtask

  task automatic test_errors();
    run_op(32'h7FC00000, 32'h3F800000, 0, "nan_x");
    run_op(32'h40000000, 32'h00000000, 0, "two_x");
    run_op(32'h3F000000, 32'h7F800000, 0, "inf_y");
    run_op(32'h00000000, 32'h00000000, 0, "zero_vec");
    run_op(32'h80000000, 32'h00000001, 0, "negzero_denorm");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      run_op(r2f(rnd()), r2f(rnd()), 0, "random");
  endtask

  task automatic test_backpressure();
    bit stray;
    run_op(32'h3F000000, 32'hBF400000, 10, "backpressure");
    stray = 1'b0;
    repeat (M + 6) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL bp_ignored_input: got out_valid=1 want 0");
    end
  endtask

  task automatic test_reset_mid_iter();
    bit stray;
    run_op(32'h3F400000, 32'h3F000000, 0, "pre_abort");
    @(negedge clk);
    in_valid = 1'b1; x_in = 32'h3F800000; y_in = 32'h3F000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_hs: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (angle !== 32'h0 || magnitude !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_out: got a=%h m=%h e=%b want 0 0 0", angle, magnitude, err);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    repeat (M + 6) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL abort_no_result: got out_valid=1 want 0");
    end
    run_op(32'h3F800000, 32'h3F000000, 0, "post_abort");
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_errors();
    test_random();
    test_backpressure();
    test_reset_mid_iter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
